network_div_div_26s_10s_16_seq: RTL and testbench

- Sequential signed fixed-point divider; the inverse of the network's 16s x 10s -> 26 multiply path.
- Divides a 26-bit signed accumulator by a 10-bit signed scale or divisor and returns a saturated 16-bit signed quotient and a 10-bit signed remainder.
- Used for re-normalising layer accumulators back to activation width.
- Iterative restoring division, one quotient bit per clock, with a start/done handshake and a clock enable matching the arithmetic cores.

---
 rtl/network_div_div_26s_10s_16_seq.sv | 193 +++++++++++++++++++
 tb/tb_network_div_div_26s_10s_16_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/network_div_div_26s_10s_16_seq.sv
// Sequential signed restoring divider: 26s / 10s -> saturated 16s quotient and 10s remainder.
// One quotient bit per enabled clock, start/done handshake, clock enable freezes all state.
module network_div_div_26s_10s_16_seq #(
    parameter int unsigned DIVIDEND_W = 26,
    parameter int unsigned DIVISOR_W  = 10,
    parameter int unsigned QUOT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] din0,
    input  logic [DIVISOR_W-1:0]  din1,
    output logic                  ready,
    output logic                  done,
    output logic [QUOT_W-1:0]     dout,
    output logic [DIVISOR_W-1:0]  rem,
    output logic                  overflow,
    output logic                  div_by_zero
);

    localparam int unsigned CNT_W  = $clog2(DIVIDEND_W);
    localparam int unsigned MAG_W  = DIVIDEND_W + 1;
    localparam int unsigned PREM_W = DIVISOR_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(DIVIDEND_W - 1);
    localparam logic [QUOT_W-1:0]     Q_MAX    = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0]     Q_MIN    = {1'b1, {(QUOT_W-1){1'b0}}};
    localparam logic [DIVIDEND_W-1:0] MAG_POS  = DIVIDEND_W'(Q_MAX);
    localparam logic [DIVIDEND_W-1:0] MAG_NEG  = DIVIDEND_W'(Q_MIN);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [MAG_W-1:0]      dvd_q, dvd_d;
    logic [PREM_W-1:0]     dsr_q, dsr_d;
    logic [PREM_W-1:0]     prem_q, prem_d;
    logic [DIVIDEND_W-1:0] quot_q, quot_d;
    logic                  qneg_q, qneg_d;
    logic                  rneg_q, rneg_d;
    logic                  dz_q, dz_d;
    logic                  ready_q, ready_d;
    logic                  done_q, done_d;
    logic [QUOT_W-1:0]     dout_q, dout_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  ovf_q, ovf_d;
    logic                  dbz_q, dbz_d;

    // Operand magnitudes, sign-extended by one bit so the most negative value does not wrap
    logic [MAG_W-1:0]  din0_sx, din0_abs;
    logic [PREM_W-1:0] din1_sx, din1_abs;
    logic [PREM_W-1:0] trial;

    always_comb begin
        din0_sx  = {din0[DIVIDEND_W-1], din0};
        din1_sx  = {din1[DIVISOR_W-1], din1};
        din0_abs = din0_sx[MAG_W-1] ? (~din0_sx + MAG_W'(1)) : din0_sx;
        din1_abs = din1_sx[PREM_W-1] ? (~din1_sx + PREM_W'(1)) : din1_sx;
        trial    = {prem_q[DIVISOR_W-1:0], dvd_q[DIVIDEND_W-1]};
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        prem_d  = prem_q;
        quot_d  = quot_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = din0_abs;
                    dsr_d   = din1_abs;
                    qneg_d  = din0[DIVIDEND_W-1] ^ din1[DIVISOR_W-1];
                    rneg_d  = din0[DIVIDEND_W-1];
                    dz_d    = (din1 == '0);
                    prem_d  = '0;
                    quot_d  = '0;
                    cnt_d   = CNT_LOAD;
                    ready_d = 1'b0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (trial >= dsr_q) begin
                    prem_d = trial - dsr_q;
                    quot_d = {quot_q[DIVIDEND_W-2:0], 1'b1};
                end else begin
                    prem_d = trial;
                    quot_d = {quot_q[DIVIDEND_W-2:0], 1'b0};
                end
                dvd_d = dvd_q << 1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIX: begin
                // Apply signs, then clamp magnitude to the signed output range
                dbz_d = dz_q;
                ovf_d = 1'b0;
                if (dz_q) begin
                    dout_d = rneg_q ? Q_MIN : Q_MAX;
                    rem_d  = '0;
                    ovf_d  = 1'b1;
                end else begin
                    rem_d = rneg_q ? (DIVISOR_W'(0) - DIVISOR_W'(prem_q)) : DIVISOR_W'(prem_q);
                    if (qneg_q) begin
                        if (quot_q > MAG_NEG) begin
                            dout_d = Q_MIN;
                            ovf_d  = 1'b1;
                        end else begin
                            dout_d = QUOT_W'(0) - QUOT_W'(quot_q);
                        end
                    end else begin
                        if (quot_q > MAG_POS) begin
                            dout_d = Q_MAX;
                            ovf_d  = 1'b1;
                        end else begin
                            dout_d = QUOT_W'(quot_q);
                        end
                    end
                end
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            default: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            quot_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            dout_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            prem_q  <= prem_d;
            quot_q  <= quot_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign dout        = dout_q;
    assign rem         = rem_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_network_div_div_26s_10s_16_seq.sv
// Self-checking bench for the sequential signed divider, compared against an integer-arithmetic model.
module tb_network_div_div_26s_10s_16_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        start;
    logic [25:0] din0;
    logic [9:0]  din1;
    logic        ready;
    logic        done;
    logic [15:0] dout;
    logic [9:0]  rem;
    logic        overflow;
    logic        div_by_zero;

    int tests = 0;
    int fails = 0;

    network_div_div_26s_10s_16_seq dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .start       (start),
        .din0        (din0),
        .din1        (din1),
        .ready       (ready),
        .done        (done),
        .dout        (dout),
        .rem         (rem),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Truncating division with saturation, built on the language's own / and % on wide integers
    task automatic model(input longint a, input longint b, output logic [15:0] q,
                         output logic [9:0] r, output logic ov, output logic dz);
        longint qq;
        longint rr;
        if (b == 0) begin
            dz = 1'b1;
            ov = 1'b1;
            r  = 10'd0;
            q  = (a >= 0) ? 16'h7fff : 16'h8000;
        end else begin
            dz = 1'b0;
            qq = a / b;
            rr = a % b;
            r  = 10'(rr);
            ov = 1'b0;
            if (qq > 32767) begin
                q  = 16'h7fff;
                ov = 1'b1;
            end else if (qq < -32768) begin
                q  = 16'h8000;
                ov = 1'b1;
            end else begin
                q = 16'(qq);
            end
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the first IDLE cycle after done
    task automatic run_op(input logic [25:0] a, input logic [9:0] b, input int stall_at,
                          input int extra_at, input int exp_lat, input string tag);
        logic [15:0] eq;
        logic [9:0]  er;
        logic        eo;
        logic        ez;
        int          cyc;
        model(longint'($signed(a)), longint'($signed(b)), eq, er, eo, ez);
        din0  = a;
        din1  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        din0  = 26'h2aaaaaa;
        din1  = 10'h155;
        cyc   = 1;
        check({tag, "_busy"}, 32'(ready), 32'd0);
        while (!done && cyc < 200) begin
            if (cyc == stall_at) ce = 1'b0;
            if (cyc == stall_at + 5) ce = 1'b1;
            if (cyc == extra_at) begin
                start = 1'b1;
                din0  = 26'd12345;
                din1  = 10'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ce    = 1'b1;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_dout"}, 32'(dout), 32'(eq));
        check({tag, "_rem"}, 32'(rem), 32'(er));
        check({tag, "_ovf"}, 32'(overflow), 32'(eo));
        check({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        logic [25:0] ra;
        logic [9:0]  rb;
        logic [15:0] held;
        int          pulses;

        reset = 1'b0;
        ce    = 1'b1;
        start = 1'b0;
        din0  = '0;
        din1  = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_rem", 32'(rem), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_op(26'd1000, 10'd7, -1, -1, 28, "p1000_7");
        run_op(-26'sd1000, 10'd7, -1, -1, 28, "n1000_7");
        run_op(26'd100000, -10'sd512, -1, -1, 28, "p100000_n512");
        run_op(26'd33554431, 10'd1, -1, -1, 28, "max_1");
        run_op(26'h2000000, -10'sd1, -1, -1, 28, "min_n1");
        run_op(-26'sd5, 10'd0, -1, -1, 28, "dz_neg");
        run_op(26'd5, 10'd0, -1, -1, 28, "dz_pos");
        run_op(26'd77777, 10'd13, 10, -1, 33, "stall");

        // A start while busy must be ignored: one done pulse, first operation's result kept
        run_op(26'd50000, 10'd9, -1, 12, 28, "ignore");
        held   = dout;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("ignore_pulses", 32'(pulses), 32'd0);
        check("ignore_hold", 32'(dout), 32'(held));

        // Abort mid-operation with an asynchronous reset
        din0  = 26'd999;
        din1  = 10'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_dout", 32'(dout), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_op(-26'sd123456, 10'd100, -1, -1, 28, "after_abort");

        for (int i = 0; i < 24; i++) begin
            ra = 26'($urandom);
            rb = 10'($urandom);
            if (i % 2 == 1) ra = 26'($urandom_range(0, 400000)) * (($urandom & 1) != 0 ? -26'sd1 : 26'sd1);
            if (i % 3 == 0) rb = 10'($urandom_range(1, 40)) * (($urandom & 1) != 0 ? -10'sd1 : 10'sd1);
            if (i == 7) rb = 10'h200;
            if (i == 11) ra = 26'h2000000;
            run_op(ra, rb, (i % 5 == 0) ? 6 : -1, -1, (i % 5 == 0) ? 33 : 28, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
